// File: rtl/rx_word_aligner_if.sv
// Bus bundle for rx_word_aligner: beat input, aligned word output and per-lane lock status.
// slip_req exists only when RX_ALIGN_MANUAL_SLIP_EN is defined.
interface rx_word_aligner_if #(
  parameter int LANES  = 1,
  parameter int DIN_W  = 6,
  parameter int WORD_W = 12,
  parameter int OFF_W  = 4
) ();
  logic [LANES*DIN_W-1:0]  din;
  logic                    din_vld;
  logic                    align_req;
`ifdef RX_ALIGN_MANUAL_SLIP_EN
  logic [LANES-1:0]        slip_req;
`endif
  logic [LANES*WORD_W-1:0] dout;
  logic                    dout_vld;
  logic [LANES-1:0]        lane_locked;
  logic                    all_locked;
  logic [LANES*OFF_W-1:0]  lane_offset;
  logic [LANES-1:0]        hunt_fail;

`ifdef RX_ALIGN_MANUAL_SLIP_EN
  modport master (
    output din, din_vld, align_req, slip_req,
    input  dout, dout_vld, lane_locked, all_locked, lane_offset, hunt_fail
  );
  modport slave (
    input  din, din_vld, align_req, slip_req,
    output dout, dout_vld, lane_locked, all_locked, lane_offset, hunt_fail
  );
`else
  modport master (
    output din, din_vld, align_req,
    input  dout, dout_vld, lane_locked, all_locked, lane_offset, hunt_fail
  );
  modport slave (
    input  din, din_vld, align_req,
    output dout, dout_vld, lane_locked, all_locked, lane_offset, hunt_fail
  );
`endif
endinterface

// File: rtl/rx_word_aligner.sv
// Multi-lane word assembler with training-pattern hunt and lock FSM on clk_rxg.
// Optional manual per-lane bit slip while locked: define RX_ALIGN_MANUAL_SLIP_EN.
module rx_word_aligner #(
  parameter int                       LANES         = 1,
  parameter int                       DIN_W         = 6,
  parameter int                       RATIO         = 2,
  parameter logic [DIN_W*RATIO-1:0]   TRAIN_PATTERN = 12'hFC0,
  parameter int                       LOCK_CNT      = 16
) (
  input  logic             clk_rxg,
  input  logic             rst_rx_n,
  rx_word_aligner_if.slave bus
);
  localparam int WORD_W = DIN_W * RATIO;
  localparam int OFF_W  = $clog2(WORD_W);
  localparam int CNT_W  = $clog2(RATIO);
  localparam int HOLD_W = WORD_W - DIN_W;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(RATIO - 1);
  localparam logic [OFF_W-1:0] LAST_OFF  = OFF_W'(WORD_W - 1);
  localparam logic [7:0]       LOCK_LAST = 8'(LOCK_CNT - 1);

  typedef enum logic [1:0] {HUNT, CHECK, LOCKED} lane_state_e;

  logic [CNT_W-1:0]        beat_cnt;
  logic                    word_tick;
  logic                    tick_d;
  logic [HOLD_W-1:0]       hold_q    [LANES];
  logic [WORD_W-1:0]       cur_q     [LANES];
  logic [WORD_W-1:0]       prev_q    [LANES];
  logic [WORD_W-1:0]       assembled [LANES];
  logic [WORD_W-1:0]       aligned   [LANES];
  lane_state_e             state_q   [LANES];
  lane_state_e             state_d   [LANES];
  logic [OFF_W-1:0]        off_q     [LANES];
  logic [OFF_W-1:0]        off_d     [LANES];
  logic [7:0]              match_q   [LANES];
  logic [7:0]              match_d   [LANES];
  logic [LANES-1:0]        settle_q, settle_d;
  logic [LANES-1:0]        fail_q, fail_d;
  logic [LANES*WORD_W-1:0] dout_q;
  logic                    dout_vld_q;

  function automatic logic [OFF_W-1:0] next_off(input logic [OFF_W-1:0] off);
    return (off == LAST_OFF) ? '0 : off + 1'b1;
  endfunction

  assign word_tick = bus.din_vld && (beat_cnt == LAST_BEAT);

  // Per-lane assembly and the window slice selected by the current offset.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [2*WORD_W-1:0] shifted;
    assign assembled[g] = {hold_q[g], bus.din[g*DIN_W +: DIN_W]};
    assign shifted      = {prev_q[g], cur_q[g]} << off_q[g];
    assign aligned[g]   = shifted[2*WORD_W-1 -: WORD_W];
    assign bus.lane_locked[g]                 = (state_q[g] == LOCKED);
    assign bus.lane_offset[g*OFF_W +: OFF_W]  = off_q[g];
  end

  assign bus.all_locked = &bus.lane_locked;
  assign bus.hunt_fail  = fail_q;
  assign bus.dout       = dout_q;
  assign bus.dout_vld   = dout_vld_q;

  always_ff @(posedge clk_rxg or negedge rst_rx_n) begin
    if (!rst_rx_n) begin
      beat_cnt <= '0;
      tick_d   <= 1'b0;
      // NOTE: these per-lane arrays are plain flops, not RAM, so they take the async reset too.
      for (int i = 0; i < LANES; i++) begin
        hold_q[i] <= '0;
        cur_q[i]  <= '0;
        prev_q[i] <= '0;
      end
    end else begin
      tick_d <= word_tick;
      if (bus.din_vld) begin
        beat_cnt <= word_tick ? '0 : beat_cnt + 1'b1;
        for (int i = 0; i < LANES; i++) begin
          hold_q[i] <= assembled[i][HOLD_W-1:0];
          if (word_tick) begin
            prev_q[i] <= cur_q[i];
            cur_q[i]  <= assembled[i];
          end
        end
      end
    end
  end

  // Output register fires one edge after the word tick, alongside the FSM evaluation.
  always_ff @(posedge clk_rxg or negedge rst_rx_n) begin
    if (!rst_rx_n) begin
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
    end else begin
      dout_vld_q <= tick_d;
      if (tick_d) begin
        for (int i = 0; i < LANES; i++) dout_q[i*WORD_W +: WORD_W] <= aligned[i];
      end
    end
  end

`ifdef RX_ALIGN_MANUAL_SLIP_EN
  logic [LANES-1:0] slip_q1, slip_q2, slip_rise;

  always_ff @(posedge clk_rxg or negedge rst_rx_n) begin
    if (!rst_rx_n) begin
      slip_q1 <= '0;
      slip_q2 <= '0;
    end else begin
      slip_q1 <= bus.slip_req;
      slip_q2 <= slip_q1;
    end
  end

  assign slip_rise = slip_q1 & ~slip_q2;
`endif

  always_ff @(posedge clk_rxg or negedge rst_rx_n) begin
    if (!rst_rx_n) begin
      settle_q <= '0;
      fail_q   <= '0;
      for (int i = 0; i < LANES; i++) begin
        state_q[i] <= HUNT;
        off_q[i]   <= '0;
        match_q[i] <= '0;
      end
    end else begin
      settle_q <= settle_d;
      fail_q   <= fail_d;
      for (int i = 0; i < LANES; i++) begin
        state_q[i] <= state_d[i];
        off_q[i]   <= off_d[i];
        match_q[i] <= match_d[i];
      end
    end
  end

  always_comb begin
    // NOTE: every next-state variable gets its hold value first, so no path can infer a latch.
    settle_d = settle_q;
    fail_d   = fail_q;
    for (int i = 0; i < LANES; i++) begin
      state_d[i] = state_q[i];
      off_d[i]   = off_q[i];
      match_d[i] = match_q[i];

      if (bus.align_req) begin
        // Restart wins over any evaluation in the same cycle; the offset is kept.
        state_d[i]  = HUNT;
        match_d[i]  = '0;
        fail_d[i]   = 1'b0;
        settle_d[i] = 1'b0;
      end else begin
        if (tick_d) begin
          if (settle_q[i]) begin
            settle_d[i] = 1'b0;
          end else begin
            unique case (state_q[i])
              HUNT: begin
                if (aligned[i] == TRAIN_PATTERN) begin
                  state_d[i] = CHECK;
                  match_d[i] = 8'd1;
                end else begin
                  off_d[i]    = next_off(off_q[i]);
                  fail_d[i]   = fail_q[i] | (off_q[i] == LAST_OFF);
                  settle_d[i] = 1'b1;
                end
              end
              CHECK: begin
                if (aligned[i] == TRAIN_PATTERN) begin
                  match_d[i] = match_q[i] + 8'd1;
                  if (match_q[i] == LOCK_LAST) state_d[i] = LOCKED;
                end else begin
                  state_d[i]  = HUNT;
                  match_d[i]  = '0;
                  off_d[i]    = next_off(off_q[i]);
                  fail_d[i]   = fail_q[i] | (off_q[i] == LAST_OFF);
                  settle_d[i] = 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
`ifdef RX_ALIGN_MANUAL_SLIP_EN
        if (slip_rise[i] && (state_q[i] == LOCKED)) off_d[i] = next_off(off_q[i]);
`endif
      end
    end
  end

endmodule
